uart_reg_bridge: RTL

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_word_fifo.sv | 53 +++++
 rtl/uart_reg_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART register bridge.
package uart_pkg;

  // Serializer / deserializer state encoding (PARITY only reached when
  // the UART_PARITY_EN build option is set).
  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  // Clocks per bit-time, truncated; clock given in MHz.
  function automatic int clks_per_bit(input int clk_fre_mhz, input int bps);
    longint unsigned num;
    num = longint'(clk_fre_mhz) * 64'd1000000;
    return int'(num / longint'(bps));
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Word FIFO for the TX path. Show-ahead read port; push while full and
// pop while empty are ignored. DEPTH must be a power of 2, >= 2.
module uart_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// UART <-> register-word bridge: buffered word TX, word-assembling RX.
// Build option: define UART_PARITY_EN for 8E1 framing (default 8N1).
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int CLK_FRE       = 50,
  parameter int BPS           = 115200,
  parameter int IDLE_CYCLE    = 20,
  parameter int REG_WIDTH     = 32,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int MSB_FIRST     = 0
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [REG_WIDTH-1:0] uart_tx_reg,
  input  logic                 uart_tx_en,
  output logic                 uart_tx_full,
  output logic                 uart_tx_drop,
  output logic                 uart_tx_busy,
  output logic [REG_WIDTH-1:0] uart_rx_reg,
  output logic                 uart_rx_ready,
  output logic                 uart_rx_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FRE, BPS);
  localparam int NBYTES       = REG_WIDTH / 8;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int BCNT_W       = $clog2(NBYTES + 1);
  localparam int IDLE_CLKS    = IDLE_CYCLE * CLKS_PER_BIT;
  localparam int IDLE_W       = $clog2(IDLE_CLKS + 1);

  localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_END  = IDLE_W'(IDLE_CLKS - 1);

  // ---------------------------------------------------------------- TX
  uart_state_e          tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [BCNT_W-1:0]    tx_byte_q, tx_byte_d;
  logic [REG_WIDTH-1:0] tx_word_q, tx_word_d;
  logic                 tx_q, tx_d;
  logic                 drop_q, drop_d;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [REG_WIDTH-1:0] fifo_dout;
  logic [7:0]           tx_cur;
  logic [2:0]           tx_nbit;
  logic                 tx_bit_end;

  uart_word_fifo #(
    .WIDTH (REG_WIDTH),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (uart_tx_en),
    .din   (uart_tx_reg),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The byte on the wire always sits at the outgoing end of tx_word_q.
  assign tx_cur     = (MSB_FIRST != 0) ? tx_word_q[REG_WIDTH-1 -: 8] : tx_word_q[7:0];
  assign tx_nbit    = tx_bit_q + 3'd1;
  assign tx_bit_end = (tx_cnt_q == BIT_END);

  assign uart_tx      = tx_q;
  assign uart_tx_full = fifo_full;
  assign uart_tx_drop = drop_q;
  assign uart_tx_busy = (tx_state_q != UART_IDLE) || !fifo_empty;

  // Serializer next state; tx_d is the line level for the coming bit, so
  // the output is registered and glitch-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_state_q == UART_IDLE || tx_bit_end) ? '0 : tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_word_d  = tx_word_q;
    tx_d       = tx_q;
    drop_d     = uart_tx_en && fifo_full;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_word_d  = fifo_dout;
          tx_byte_d  = '0;
          tx_state_d = UART_START;
          tx_d       = 1'b0;
        end
      end
      UART_START: begin
        if (tx_bit_end) begin
          tx_bit_d   = 3'd0;
          tx_state_d = UART_DATA;
          tx_d       = tx_cur[0];
        end
      end
      UART_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = UART_PARITY;
            tx_d       = ^tx_cur;
`else
            tx_state_d = UART_STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d = tx_nbit;
            tx_d     = tx_cur[tx_nbit];
          end
        end
      end
`ifdef UART_PARITY_EN
      UART_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = UART_STOP;
          tx_d       = 1'b1;
        end
      end
`endif
      UART_STOP: begin
        if (tx_bit_end) begin
          if (tx_byte_q == LAST_BYTE) begin
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              tx_word_d  = fifo_dout;
              tx_byte_d  = '0;
              tx_state_d = UART_START;
              tx_d       = 1'b0;
            end else begin
              tx_state_d = UART_IDLE;
              tx_d       = 1'b1;
            end
          end else begin
            tx_byte_d  = tx_byte_q + BCNT_W'(1);
            tx_word_d  = (MSB_FIRST != 0) ? (tx_word_q << 8) : (tx_word_q >> 8);
            tx_state_d = UART_START;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        tx_state_d = UART_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // Serializer registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_word_q  <= '0;
      tx_q       <= 1'b1;
      drop_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_word_q  <= tx_word_d;
      tx_q       <= tx_d;
      drop_q     <= drop_d;
    end
  end

  // ---------------------------------------------------------------- RX
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e          rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [7:0]           rx_byte_q, rx_byte_d;
  logic [BCNT_W-1:0]    rx_nbytes_q, rx_nbytes_d;
  logic [REG_WIDTH-1:0] rx_word_q, rx_word_d;
  logic [REG_WIDTH-1:0] rx_reg_q, rx_reg_d;
  logic                 rx_rdy_q, rx_rdy_d;
  logic                 rx_err_q, rx_err_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 rx_fall, rx_end, rx_good;
  logic [REG_WIDTH-1:0] rx_word_new;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d;
`endif

  assign rx_fall = rx_prev_q && !rx_s2_q;
  assign rx_end  = (rx_state_q == UART_START) ? (rx_cnt_q == HALF_END) : (rx_cnt_q == BIT_END);
`ifdef UART_PARITY_EN
  assign rx_good = rx_s2_q && (rx_par_q == ^rx_byte_q);
`else
  assign rx_good = rx_s2_q;
`endif
  // Byte 0 on the wire ends in bits 7:0 (or the top byte with MSB_FIRST).
  assign rx_word_new = (MSB_FIRST != 0) ?
      ((rx_word_q << 8) | REG_WIDTH'(rx_byte_q)) :
      ((rx_word_q >> 8) | (REG_WIDTH'(rx_byte_q) << (REG_WIDTH - 8)));

  assign uart_rx_reg   = rx_reg_q;
  assign uart_rx_ready = rx_rdy_q;
  assign uart_rx_err   = rx_err_q;

  // Deserializer next state plus partial-word idle timeout.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = (rx_state_q == UART_IDLE || rx_end) ? '0 : rx_cnt_q + CNT_W'(1);
    rx_bit_d    = rx_bit_q;
    rx_byte_d   = rx_byte_q;
    rx_nbytes_d = rx_nbytes_q;
    rx_word_d   = rx_word_q;
    rx_reg_d    = rx_reg_q;
    rx_rdy_d    = 1'b0;
    rx_err_d    = 1'b0;
    idle_cnt_d  = '0;
`ifdef UART_PARITY_EN
    rx_par_d    = rx_par_q;
`endif
    case (rx_state_q)
      UART_IDLE: begin
        if (rx_fall) rx_state_d = UART_START;
        if (rx_nbytes_q != '0 && rx_s2_q) begin
          if (idle_cnt_q == IDLE_END) begin
            rx_nbytes_d = '0;
            rx_err_d    = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end
      UART_START: begin
        if (rx_end) begin
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? UART_IDLE : UART_DATA;
        end
      end
      UART_DATA: begin
        if (rx_end) begin
          rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
          rx_bit_d  = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = UART_PARITY;
`else
            rx_state_d = UART_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      UART_PARITY: begin
        if (rx_end) begin
          rx_par_d   = rx_s2_q;
          rx_state_d = UART_STOP;
        end
      end
`endif
      UART_STOP: begin
        if (rx_end) begin
          rx_state_d = UART_IDLE;
          if (rx_good) begin
            rx_word_d = rx_word_new;
            if (rx_nbytes_q == LAST_BYTE) begin
              rx_reg_d    = rx_word_new;
              rx_rdy_d    = 1'b1;
              rx_nbytes_d = '0;
            end else begin
              rx_nbytes_d = rx_nbytes_q + BCNT_W'(1);
            end
          end else begin
            rx_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = UART_IDLE;
    endcase
  end

  // Synchronizer and deserializer registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= UART_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_byte_q   <= '0;
      rx_nbytes_q <= '0;
      rx_word_q   <= '0;
      rx_reg_q    <= '0;
      rx_rdy_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      idle_cnt_q  <= '0;
`ifdef UART_PARITY_EN
      rx_par_q    <= 1'b0;
`endif
    end else begin
      rx_s1_q     <= uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_byte_q   <= rx_byte_d;
      rx_nbytes_q <= rx_nbytes_d;
      rx_word_q   <= rx_word_d;
      rx_reg_q    <= rx_reg_d;
      rx_rdy_q    <= rx_rdy_d;
      rx_err_q    <= rx_err_d;
      idle_cnt_q  <= idle_cnt_d;
`ifdef UART_PARITY_EN
      rx_par_q    <= rx_par_d;
`endif
    end
  end

endmodule
